// File: rtl/mldsa_hint_unit.sv
// Streaming ML-DSA Decompose/MakeHint/UseHint engine; sec_level (44/65/87) and op latched per job. Macro MLDSA_HINT_GAMMA88_EN compiles in the (q-1)/88 path.
// Latency: 3 cycles from input accept to out_valid, 1 beat/cycle throughput.
// Backpressure: out_ready low with stage 3 full freezes every stage and drops in_ready; no beat is lost or repeated.
module mldsa_hint_unit #(
    parameter int Q       = 8380417,
    parameter int COEFF_W = 23,
    parameter int N       = 256,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         sec_level,
    input  logic               op,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_a,
    input  logic [COEFF_W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_data,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   hint_count,
    output logic               omega_err,
    output logic               mode_err
);

`ifdef MLDSA_HINT_GAMMA88_EN
    localparam bit G88_EN = 1'b1;
`else
    localparam bit G88_EN = 1'b0;
`endif
    localparam int          CW      = $clog2(N);
    localparam logic [31:0] TWO_G32 = 32'((Q - 1) / 16);
    localparam logic [31:0] TWO_G88 = 32'((Q - 1) / 44);
    localparam int          HALF_Q  = (Q - 1) / 2;

    // Returns {r0 > 0, r1}. r1 comes from a rounded reciprocal multiply; the top
    // bucket (r1 = m) folds to 0 and r0 is re-centred, which yields the r0 = -1
    // special case at r = q-1 without a separate compare.
    function automatic logic [6:0] decompose(input logic [COEFF_W-1:0] a, input logic g88);
        logic [31:0] t;
        logic [31:0] r1;
        int          r0;
        t = (32'(a) + 32'd127) >> 7;
        if (g88) begin
            r1 = (t * 32'd11275 + 32'd8388608) >> 24;
            if (r1 > 32'd43) r1 = 32'd0;
        end else begin
            r1 = ((t * 32'd1025 + 32'd2097152) >> 22) & 32'd15;
        end
        r0 = $signed(32'(a)) - $signed(r1 * (g88 ? TWO_G88 : TWO_G32));
        if (r0 > HALF_Q) r0 = r0 - Q;
        return {r0 > 0, r1[5:0]};
    endfunction

    logic               busy_q, busy_d, op_q, op_d, g88_q, g88_d;
    logic [2:0]         last_poly_q, last_poly_d;
    logic [6:0]         omega_q, omega_d;
    logic [CW-1:0]      in_coeff_q, in_coeff_d, out_coeff_q, out_coeff_d;
    logic [2:0]         in_poly_q, in_poly_d, out_poly_q, out_poly_d;
    logic               in_fin_q, in_fin_d;
    logic [CNT_W-1:0]   hint_count_q, hint_count_d;
    logic               omega_err_q, omega_err_d, mode_err_q, mode_err_d, done_q, done_d;
    logic               s1_vld_q, s1_vld_d, s1_h_q, s1_h_d;
    logic [COEFF_W-1:0] s1_r_q, s1_r_d, s1_s_q, s1_s_d;
    logic               s2_vld_q, s2_vld_d, s2_r0p_q, s2_r0p_d, s2_h_q, s2_h_d;
    logic [5:0]         s2_r1r_q, s2_r1r_d, s2_r1s_q, s2_r1s_d;
    logic               s3_vld_q, s3_vld_d;
    logic [5:0]         s3_dat_q, s3_dat_d;

    logic               g88, adv, in_fire, out_fire, last_out, sec_ok, wrap;
    logic [2:0]         sec_last;
    logic [6:0]         sec_omega;
    logic [COEFF_W:0]   sum_raw;
    logic [COEFF_W-1:0] sum_mod;
    logic [6:0]         dec_r, dec_s;
    logic [5:0]         m_max, res;

    assign g88      = G88_EN & g88_q;
    assign adv      = !s3_vld_q || out_ready;
    assign in_ready = busy_q && !in_fin_q && adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s3_vld_q && out_ready;
    assign last_out = out_fire && (out_poly_q == last_poly_q) && (out_coeff_q == CW'(N - 1));
    assign sum_raw  = {1'b0, in_a} + {1'b0, in_b};
    assign wrap     = sum_raw >= (COEFF_W + 1)'(Q);
    assign sum_mod  = in_a + in_b - (wrap ? COEFF_W'(Q) : '0);
    assign dec_r    = decompose(s1_r_q, g88);
    assign dec_s    = decompose(s1_s_q, g88);
    assign m_max    = g88 ? 6'd43 : 6'd15;

    // Stage-3 result: hint bit for MakeHint, adjusted high bits for UseHint.
    always_comb begin
        res = s2_r1r_q;
        if (!op_q)             res = {5'd0, s2_r1r_q != s2_r1s_q};
        else if (!s2_h_q)      res = s2_r1r_q;
        else if (s2_r0p_q)     res = (s2_r1r_q == m_max) ? 6'd0 : s2_r1r_q + 6'd1;
        else                   res = (s2_r1r_q == 6'd0) ? m_max : s2_r1r_q - 6'd1;
    end

    // Job control, beat counters, hint accounting and pipeline advance.
    always_comb begin
        busy_d = busy_q;   op_d = op_q;   g88_d = g88_q;
        last_poly_d = last_poly_q;   omega_d = omega_q;
        in_coeff_d = in_coeff_q;     in_poly_d = in_poly_q;     in_fin_d = in_fin_q;
        out_coeff_d = out_coeff_q;   out_poly_d = out_poly_q;
        hint_count_d = hint_count_q; omega_err_d = omega_err_q; mode_err_d = mode_err_q;
        done_d = 1'b0;
        s1_vld_d = s1_vld_q; s1_r_d = s1_r_q; s1_s_d = s1_s_q; s1_h_d = s1_h_q;
        s2_vld_d = s2_vld_q; s2_r1r_d = s2_r1r_q; s2_r1s_d = s2_r1s_q; s2_r0p_d = s2_r0p_q; s2_h_d = s2_h_q;
        s3_vld_d = s3_vld_q; s3_dat_d = s3_dat_q;
        sec_ok = 1'b0; sec_last = 3'd0; sec_omega = 7'd0;
        case (sec_level)
            2'd0:    begin sec_ok = G88_EN; sec_last = 3'd3; sec_omega = 7'd80; end
            2'd1:    begin sec_ok = 1'b1;   sec_last = 3'd5; sec_omega = 7'd55; end
            2'd2:    begin sec_ok = 1'b1;   sec_last = 3'd7; sec_omega = 7'd75; end
            default: begin sec_ok = 1'b0;   sec_last = 3'd0; sec_omega = 7'd0;  end
        endcase

        if (!busy_q && start) begin
            hint_count_d = '0; omega_err_d = 1'b0;
            in_coeff_d = '0; in_poly_d = '0; in_fin_d = 1'b0;
            out_coeff_d = '0; out_poly_d = '0;
            if (sec_ok) begin
                busy_d = 1'b1; op_d = op; g88_d = (sec_level == 2'd0);
                last_poly_d = sec_last; omega_d = sec_omega; mode_err_d = 1'b0;
            end else begin
                mode_err_d = 1'b1; done_d = 1'b1;
            end
        end

        if (in_fire) begin
            if (in_coeff_q == CW'(N - 1)) begin
                in_coeff_d = '0;
                if (in_poly_q == last_poly_q) in_fin_d  = 1'b1;
                else                          in_poly_d = in_poly_q + 3'd1;
            end else begin
                in_coeff_d = in_coeff_q + 1'b1;
            end
        end

        if (out_fire) begin
            if (!op_q && s3_dat_q[0] && (hint_count_q != {CNT_W{1'b1}}))
                hint_count_d = hint_count_q + 1'b1;
            if (out_coeff_q == CW'(N - 1)) begin
                out_coeff_d = '0;
                out_poly_d  = out_poly_q + 3'd1;
            end else begin
                out_coeff_d = out_coeff_q + 1'b1;
            end
            if (last_out) begin
                busy_d = 1'b0; done_d = 1'b1; in_fin_d = 1'b0;
            end
        end

        if (busy_q && !op_q)
            omega_err_d = omega_err_q || (hint_count_d > CNT_W'(omega_q));

        if (adv) begin
            s1_vld_d = in_fire;  s1_r_d = in_a; s1_s_d = sum_mod; s1_h_d = in_b[0];
            s2_vld_d = s1_vld_q; s2_r1r_d = dec_r[5:0]; s2_r0p_d = dec_r[6];
            s2_r1s_d = dec_s[5:0]; s2_h_d = s1_h_q;
            s3_vld_d = s2_vld_q; s3_dat_d = res;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0; op_q <= 1'b0; g88_q <= 1'b0; last_poly_q <= '0; omega_q <= '0;
            in_coeff_q <= '0; in_poly_q <= '0; in_fin_q <= 1'b0; out_coeff_q <= '0; out_poly_q <= '0;
            hint_count_q <= '0; omega_err_q <= 1'b0; mode_err_q <= 1'b0; done_q <= 1'b0;
            s1_vld_q <= 1'b0; s1_r_q <= '0; s1_s_q <= '0; s1_h_q <= 1'b0;
            s2_vld_q <= 1'b0; s2_r1r_q <= '0; s2_r1s_q <= '0; s2_r0p_q <= 1'b0; s2_h_q <= 1'b0;
            s3_vld_q <= 1'b0; s3_dat_q <= '0;
        end else begin
            busy_q <= busy_d; op_q <= op_d; g88_q <= g88_d; last_poly_q <= last_poly_d; omega_q <= omega_d;
            in_coeff_q <= in_coeff_d; in_poly_q <= in_poly_d; in_fin_q <= in_fin_d;
            out_coeff_q <= out_coeff_d; out_poly_q <= out_poly_d;
            hint_count_q <= hint_count_d; omega_err_q <= omega_err_d; mode_err_q <= mode_err_d; done_q <= done_d;
            s1_vld_q <= s1_vld_d; s1_r_q <= s1_r_d; s1_s_q <= s1_s_d; s1_h_q <= s1_h_d;
            s2_vld_q <= s2_vld_d; s2_r1r_q <= s2_r1r_d; s2_r1s_q <= s2_r1s_d; s2_r0p_q <= s2_r0p_d; s2_h_q <= s2_h_d;
            s3_vld_q <= s3_vld_d; s3_dat_q <= s3_dat_d;
        end
    end

    assign out_valid  = s3_vld_q;
    assign out_data   = s3_dat_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hint_count = hint_count_q;
    assign omega_err  = omega_err_q;
    assign mode_err   = mode_err_q;

endmodule

// File: doc/mldsa_hint_unit.md
# mldsa_hint_unit

Streaming Decompose/MakeHint/UseHint engine for all three ML-DSA parameter sets (44/65/87), selected at run time per job. It sits between the NTT/arithmetic datapath and the signature packer: in signing it produces hint bits and a running hint count with the ω bound check; in verification it recovers w1' coefficients from hints. It generalises the fixed ML-DSA-87 constants (q = 8380417, γ2 = (q-1)/32, k = 8, ω = 75) into a latched per-job mode.

## Interface
- Q, 8380417, field modulus
- COEFF_W, 23, coefficient width
- N, 256, coefficients per polynomial
- CNT_W, 12, width of coefficient and hint counters (≥ log2(8·N)+1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; synchronous, active-low
- start  in  1  job start pulse; sampled only when busy = 0
- sec_level  in  2  0 = ML-DSA-44 (γ2=(q-1)/88, k=4, ω=80); 1 = ML-DSA-65 (γ2=(q-1)/32, k=6, ω=55); 2 = ML-DSA-87 (γ2=(q-1)/32, k=8, ω=75); 3 = reserved
- op  in  1  0 = MakeHint, 1 = UseHint; latched with sec_level at start
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_a  in  COEFF_W  r, in [0,Q)
- in_b  in  COEFF_W  MakeHint: z in [0,Q); UseHint: bit 0 = h, others ignored
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_data  out  6  MakeHint: hint bit in bit 0, upper bits 0; UseHint: w1' in [0, 2^... m-1] (m = 16 or 44)
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- hint_count  out  CNT_W  MakeHint: number of 1 hints in job; UseHint: 0
- omega_err  out  1  MakeHint: hint_count > ω; held until next start
- mode_err  out  1  start with reserved/disabled sec_level; held until next start

## Operation
- Idle: busy = 0, in_ready = 0. start with a valid sec_level latches sec_level/op, clears counters, omega_err, mode_err, busy ← 1 next cycle.
- Invalid sec_level at start: mode_err ← 1, busy stays 0, done pulses next cycle.
- Job accepts exactly k·N input beats, produces exactly k·N output beats in order; then done pulses, busy ← 0.
- Decompose(r): r0 = r mod± 2γ2 (range (-γ2, γ2]); if r - r0 = Q-1 then r1 = 0, r0 = r0 - 1; else r1 = (r - r0)/(2γ2). Bit-exact to FIPS 204; no divider — constant reciprocal multiply or compare ladder allowed.
- MakeHint: s = (r + z) mod Q; out = (HighBits(r) ≠ HighBits(s)).
- UseHint: m = (Q-1)/(2γ2) (16 or 44); h = 0 → r1; h = 1 and r0 > 0 → (r1+1) mod m; h = 1 and r0 ≤ 0 → (r1-1) mod m.
- hint_count increments per MakeHint output 1; saturates at 2^CNT_W - 1. omega_err set combinationally from count vs. latched ω, registered.
- Coefficient counter wraps N per poly; poly index up to k-1; last beat = (poly = k-1, coeff = N-1).

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0, hint_count 0, omega_err 0, mode_err 0; pipeline emptied, counters 0.
- 3-stage pipeline (mod-reduce/add, decompose, hint/adjust): latency 3 cycles input accept → out_valid with no backpressure; throughput 1 beat/cycle.
- in_ready = busy & (accepted < k·N) & (stage 3 empty or out_ready); full stall on out_ready = 0, no beat dropped or duplicated.
- out_data stable while out_valid & !out_ready.
- done asserts the cycle after the final output handshake; hint_count/omega_err valid that same cycle and held.
- start while busy ignored. rst_n low mid-job aborts immediately to reset state; no done.

## Configuration
- MLDSA_HINT_GAMMA88_EN: defined → γ2 = (q-1)/88 datapath (sec_level 0) compiled in. Undefined → only γ2 = (q-1)/32 logic present; sec_level 0 treated as reserved (mode_err = 1, no job).

## Test plan
- sec_level 2, MakeHint, r = 261888, z = 1 → out bit 1; r = 0, z = 0 → 0; output 3 cycles after accept.
- sec_level 2, UseHint, r = 8380416, h = 1 → 15; r = 261889, h = 1 → 0; h = 0, r = 261889 → 1.
- sec_level 0 (macro defined), UseHint, r = 8380416, h = 1 → 43; macro undefined → mode_err = 1, busy stays 0.
- sec_level 0 MakeHint job of 1024 beats with 81 hint-1 pairs → hint_count = 81, omega_err = 1 at done; 80 pairs → omega_err = 0.
- Random out_ready toggling (50%) over full ML-DSA-65 job (1536 beats) → outputs match golden model in order, done once, exactly 1536 output handshakes.
- rst_n low at beat 100 of a job → all outputs reset next cycle; new start runs full job correctly.
